// File: rtl/stream_demux6.sv
`default_nettype none
// ============================================================================
// stream_demux6 : registered 1-to-6 valid/ready stream demultiplexer with
//                 illegal-select drop and saturating error counter.
// Revision      : 1.0
// ============================================================================
module stream_demux6 #(
  parameter int DATA_W    = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_sel,
  input  logic [DATA_W-1:0]    in_data,
  output logic [5:0]           out_valid,
  input  logic [5:0]           out_ready,
  output logic [DATA_W-1:0]    out_data0,
  output logic [DATA_W-1:0]    out_data1,
  output logic [DATA_W-1:0]    out_data2,
  output logic [DATA_W-1:0]    out_data3,
  output logic [DATA_W-1:0]    out_data4,
  output logic [DATA_W-1:0]    out_data5,
  input  logic                 err_clr,
  output logic                 err_flag,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  logic [5:0]             valid_q, valid_d;
  logic [5:0][DATA_W-1:0] data_q;
  logic                   err_flag_q, err_flag_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic [5:0] free;
  logic [5:0] load;
  logic       legal;
  logic       sel_free;
  logic       accept;
  logic       ill_accept;

  // Illegal selects are always accepted so they can be dropped and counted.
  always_comb begin
    free     = ~valid_q | out_ready;
    legal    = (in_sel < 3'd6);
    sel_free = 1'b1;
    case (in_sel)
      3'd0:    sel_free = free[0];
      3'd1:    sel_free = free[1];
      3'd2:    sel_free = free[2];
      3'd3:    sel_free = free[3];
      3'd4:    sel_free = free[4];
      3'd5:    sel_free = free[5];
      default: sel_free = 1'b1;
    endcase
    in_ready   = sel_free;
    accept     = in_valid & sel_free;
    ill_accept = accept & ~legal;
    load       = '0;
    for (int n = 0; n < 6; n++) begin
      load[n] = accept & (in_sel == 3'(n));
    end
    valid_d = (valid_q & ~out_ready) | load;
  end

  // A new illegal event takes priority over a simultaneous clear.
  always_comb begin
    err_flag_d = err_flag_q;
    err_cnt_d  = err_cnt_q;
    if (ill_accept) begin
      err_flag_d = 1'b1;
      if (err_clr) begin
        err_cnt_d = ERR_CNT_W'(1);
      end else if (err_cnt_q != {ERR_CNT_W{1'b1}}) begin
        err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end
    end else if (err_clr) begin
      err_flag_d = 1'b0;
      err_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= '0;
      data_q     <= '0;
      err_flag_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      valid_q    <= valid_d;
      err_flag_q <= err_flag_d;
      err_cnt_q  <= err_cnt_d;
      for (int n = 0; n < 6; n++) begin
        if (load[n]) data_q[n] <= in_data;
      end
    end
  end

  assign out_valid = valid_q;
  assign out_data0 = data_q[0];
  assign out_data1 = data_q[1];
  assign out_data2 = data_q[2];
  assign out_data3 = data_q[3];
  assign out_data4 = data_q[4];
  assign out_data5 = data_q[5];
  assign err_flag  = err_flag_q;
  assign err_cnt   = err_cnt_q;

endmodule
`default_nettype wire
